// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA 640x480@60 timing defaults and pixel/colour types
package vga_timing_pkg;
   localparam int DEF_CLK_DIV      = 2;
   localparam int DEF_H_VISIBLE    = 640;
   localparam int DEF_H_SYNC_START = 656;
   localparam int DEF_H_SYNC_END   = 752;
   localparam int DEF_H_TOTAL      = 800;
   localparam int DEF_V_VISIBLE    = 480;
   localparam int DEF_V_SYNC_START = 490;
   localparam int DEF_V_SYNC_END   = 492;
   localparam int DEF_V_TOTAL      = 525;
   typedef logic [10:0] coord_t;
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;
endpackage

// File: rtl/vga_scan_counter.sv
// vga_scan_counter: pixel-clock divider, hc/vc raster counters and per-frame tick
module vga_scan_counter
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int H_TOTAL   = DEF_H_TOTAL,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_TOTAL   = DEF_V_TOTAL
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic        pix_en,
   output logic [10:0] hc,
   output logic [10:0] vc,
   output logic        frame_clk,
   output logic        vga_clk
);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
   localparam coord_t V_PRE_BLANK = coord_t'(V_VISIBLE - 1);
   logic [DW-1:0] div_cnt, div_nxt;
   logic          h_wrap;
   assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
   assign pix_en  = (div_cnt == DIV_LAST) && !Reset;
   assign h_wrap  = hc == H_LAST;
   // Advance the divider every Clk and the raster on pix_en; frame_clk marks entry to (0, V_VISIBLE)
   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_cnt   <= '0;
         vga_clk   <= 1'b0;
         frame_clk <= 1'b0;
         hc        <= '0;
         vc        <= '0;
      end else begin
         div_cnt   <= div_nxt;
         vga_clk   <= div_nxt >= DIV_HALF;
         frame_clk <= pix_en && h_wrap && vc == V_PRE_BLANK;
         if (pix_en) begin
            hc <= h_wrap ? '0 : hc + 1'b1;
            if (h_wrap) vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
         end
      end
   end
endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: raster scan for the colour mapper plus registered VGA DAC outputs
module vga_scan_driver
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int H_VISIBLE    = DEF_H_VISIBLE,
   parameter int H_SYNC_START = DEF_H_SYNC_START,
   parameter int H_SYNC_END   = DEF_H_SYNC_END,
   parameter int H_TOTAL      = DEF_H_TOTAL,
   parameter int V_VISIBLE    = DEF_V_VISIBLE,
   parameter int V_SYNC_START = DEF_V_SYNC_START,
   parameter int V_SYNC_END   = DEF_V_SYNC_END,
   parameter int V_TOTAL      = DEF_V_TOTAL
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [7:0]  Red_In,
   input  logic [7:0]  Green_In,
   input  logic [7:0]  Blue_In,
   output logic [10:0] DrawX,
   output logic [10:0] DrawY,
   output logic        pix_en,
   output logic        frame_clk,
   output logic        VGA_CLK,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B
);
   localparam coord_t HV  = coord_t'(H_VISIBLE);
   localparam coord_t HSS = coord_t'(H_SYNC_START);
   localparam coord_t HSE = coord_t'(H_SYNC_END);
   localparam coord_t VV  = coord_t'(V_VISIBLE);
   localparam coord_t VSS = coord_t'(V_SYNC_START);
   localparam coord_t VSE = coord_t'(V_SYNC_END);
   coord_t hc, vc;
   rgb_t   in_rgb, out_rgb;
   logic   visible;
   vga_scan_counter #(
      .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .V_VISIBLE(V_VISIBLE), .V_TOTAL(V_TOTAL)
   ) u_cnt (
      .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .hc(hc), .vc(vc),
      .frame_clk(frame_clk), .vga_clk(VGA_CLK)
   );
   assign DrawX      = hc;
   assign DrawY      = vc;
   assign VGA_SYNC_N = 1'b0;
   assign in_rgb     = '{r: Red_In, g: Green_In, b: Blue_In};
   assign visible    = hc < HV && vc < VV;
   assign VGA_R      = out_rgb.r;
   assign VGA_G      = out_rgb.g;
   assign VGA_B      = out_rgb.b;
   // Register colour, blank and sync for the pixel being presented, one pixel behind DrawX/DrawY
   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_rgb     <= '0;
         VGA_BLANK_N <= 1'b0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
      end else if (pix_en) begin
         out_rgb     <= visible ? in_rgb : '0;
         VGA_BLANK_N <= visible;
         VGA_HS      <= !(hc >= HSS && hc < HSE);
         VGA_VS      <= !(vc >= VSS && vc < VSE);
      end
   end
endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: scoreboard bench; full-width lines, frame shortened to 12 lines to keep run length small
module tb_vga_scan_driver;
   localparam int HT = 800, HV = 640, HSS = 656, HSE = 752;
   localparam int VT = 12, VV = 6, VSS = 8, VSE = 10;
   localparam int FP = HT * VT;
   localparam int MID_C = 2 * (2 * FP + 3 * HT + 300) - 1;
   logic        Clk = 1'b0, Reset = 1'b1;
   logic [7:0]  Red_In = 8'hFF, Green_In = 8'h00, Blue_In = 8'h00;
   logic [10:0] DrawX, DrawY;
   logic        pix_en, frame_clk, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   int checks = 0, errors = 0;
   int c = 0, cyc = 0, rst_cyc = 0, last_pulse = -1, pulses = 0, hs_run = 0, vs_run = 0;
   logic cur_rst = 1'b1;
   typedef struct {
      logic [10:0] x, y;
      logic [6:0]  flags;
      logic [23:0] rgb;
   } exp_t;
   exp_t q[$];

   vga_scan_driver #(
      .CLK_DIV(2), .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
      .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Red_In(Red_In), .Green_In(Green_In), .Blue_In(Blue_In),
      .DrawX(DrawX), .DrawY(DrawY), .pix_en(pix_en), .frame_clk(frame_clk), .VGA_CLK(VGA_CLK),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );

   always #5 Clk = ~Clk;

   // flags = {pix_en, VGA_CLK, frame_clk, HS, VS, BLANK_N, SYNC_N}
   function automatic exp_t reset_rec();
      exp_t e;
      e.x = '0; e.y = '0; e.flags = 7'b0001100; e.rgb = '0;
      return e;
   endfunction

   // Closed-form expectation for cycle c after the first non-reset edge
   function automatic exp_t model(int cc);
      exp_t e;
      int pix = (cc + 1) / 2;
      int p = pix % FP;
      int o = (pix + FP - 1) % FP;
      int ox = o % HT, oy = o / HT;
      logic vis = ox < HV && oy < VV;
      logic ev = (cc % 2) == 0;
      e.x = 11'(p % HT);
      e.y = 11'(p / HT);
      e.flags = {ev, ev, !ev && p == VV * HT, !(ox >= HSS && ox < HSE), !(oy >= VSS && oy < VSE), vis, 1'b0};
      e.rgb = vis ? 24'h28FA46 : 24'h0;
      return e;
   endfunction

   task automatic step(input logic rst_next);
      exp_t e;
      @(posedge Clk);
      #1;
      if (cur_rst) begin
         e = reset_rec();
         c = 0;
      end else begin
         e = model(c);
         c++;
      end
      e.flags[6] = e.flags[6] && !rst_next;
      q.push_back(e);
      Reset = rst_next;
      cur_rst = rst_next;
   endtask

   // Monitor: pop one expected record per Clk and compare every output
   always @(negedge Clk) begin
      exp_t e;
      logic [6:0] got_f;
      if (q.size() > 0) begin
         e = q.pop_front();
         got_f = {pix_en, VGA_CLK, frame_clk, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N};
         checks++;
         if (DrawX !== e.x || DrawY !== e.y || got_f !== e.flags || {VGA_R, VGA_G, VGA_B} !== e.rgb) begin
            errors++;
            $display("FAIL scan t=%0t: got x=%0d y=%0d flags=%b rgb=%h, want x=%0d y=%0d flags=%b rgb=%h",
                     $time, DrawX, DrawY, got_f, {VGA_R, VGA_G, VGA_B}, e.x, e.y, e.flags, e.rgb);
         end
      end
   end

   // Independent run-length checks on sync pulses and frame_clk spacing
   always @(negedge Clk) begin
      int want, got;
      cyc++;
      if (VGA_HS === 1'b0) hs_run++;
      else if (hs_run > 0) begin
         checks++;
         if (hs_run != 2 * (HSE - HSS)) begin
            errors++;
            $display("FAIL hs_width: got %0d Clk, want %0d", hs_run, 2 * (HSE - HSS));
         end
         hs_run = 0;
      end
      if (VGA_VS === 1'b0) vs_run++;
      else if (vs_run > 0) begin
         checks++;
         if (vs_run != 2 * HT * (VSE - VSS)) begin
            errors++;
            $display("FAIL vs_width: got %0d Clk, want %0d", vs_run, 2 * HT * (VSE - VSS));
         end
         vs_run = 0;
      end
      if (Reset) begin
         rst_cyc = cyc;
         last_pulse = -1;
      end
      if (frame_clk === 1'b1) begin
         pulses++;
         checks++;
         want = (last_pulse < 0) ? 2 * HT * VV : 2 * FP;
         got = (last_pulse < 0) ? cyc - rst_cyc - 1 : cyc - last_pulse;
         if (got != want) begin
            errors++;
            $display("FAIL frame_gap: got %0d Clk, want %0d", got, want);
         end
         last_pulse = cyc;
      end
   end

   initial begin
      step(1'b1);
      step(1'b1);
      step(1'b0);
      Red_In = 8'h28;
      Green_In = 8'hFA;
      Blue_In = 8'h46;
      while (c < MID_C) step(1'b0);
      step(1'b1);
      step(1'b0);
      repeat (9700) step(1'b0);
      repeat (2) @(posedge Clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d left, want 0", q.size());
      end
      checks++;
      if (pulses != 3) begin
         errors++;
         $display("FAIL frame_count: got %0d pulses, want 3", pulses);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
